cache_fill_arbiter: RTL and testbench
=====================================

# cache_fill_arbiter

Shares one SDRAM controller read port between two cache instances (instruction-side client 0 and data-side client 1). Each cache issues a line-fill request with a held address. The arbiter grants one client at a time round-robin and forwards its address to the controller. It routes the controller's first-word strobe back to that client only, and keeps the grant for the full burst so data words cannot be mis-steered.

## Interface
Parameters:
- ADDR_W, 32: width of client and SDRAM addresses.
- BURST_LEN, 4: words per line fill, counting the strobed first word; must be ≥2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- c0_req  in  1  client 0 fill request; held high until c0_fill is seen.
- c0_addr  in  ADDR_W  client 0 burst-aligned address; stable while c0_req high.
- c0_rw  in  1  client 0 direction, 1=read.
- c0_fill  out  1  first-word strobe to client 0.
- c1_req, c1_addr, c1_rw, c1_fill: same as client 0, for client 1.
- sdram_req  out  1  request to controller.
- sdram_addr  out  ADDR_W  latched address of the granted client.
- sdram_rw  out  1  latched direction of the granted client.
- sdram_fill  in  1  controller first-word strobe; one cycle, followed by BURST_LEN-1 consecutive data cycles.
- grant  out  2  one-hot owner of the port, 00 when idle; for debug and observability.

Data from the controller goes directly to both clients. Only the strobed client consumes it, so the arbiter does not carry a data bus.

## Operation
State machine: IDLE, WAITFILL, BURST.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that client.
  - Both requests: grant the client not in last_grant.
  - On grant:
    - Latch its addr and rw into sdram_addr and sdram_rw.
    - Set sdram_req=1 and grant to the client's one-hot value.
    - Set last_grant to the granted client.
    - Go to WAITFILL.
- **WAITFILL**
  - Hold sdram_req, sdram_addr and sdram_rw.
  - On sdram_fill=1:
    - Clear sdram_req (registered).
    - Load word counter wcnt with BURST_LEN-2.
    - Go to BURST.
- **BURST**
  - When wcnt=0: clear grant and go to IDLE.
  - Otherwise: decrement wcnt.
  - The BURST state spans exactly BURST_LEN-1 cycles, one per trailing data word.
- **Fill steering**
  - c0_fill = sdram_fill & state==WAITFILL & grant[0].
  - c1_fill = sdram_fill & state==WAITFILL & grant[1].
  - Both are combinational, so the client sees the strobe in the same cycle as the data word.
  - sdram_fill in any state other than WAITFILL is ignored. No client is strobed and no state changes.
- **Requests during a grant**
  - Requests from either client are ignored outside IDLE.
  - A waiting client keeps its req high and is served next.
- **Granted client drops req before fill** (for example, the cache was reset)
  - The arbiter still waits for sdram_fill and completes the burst, because the controller has already committed to it.
  - The strobe is still driven to the client, which is expected to ignore it.
- **Reset (asynchronous, any state, including mid-burst)**
  - state=IDLE, sdram_req=0, sdram_addr=0, sdram_rw=1.
  - grant=00, c0_fill=c1_fill=0, wcnt=0.
  - last_grant=client 1, so client 0 wins the first tie.

## Timing
- Request to sdram_req: 1 cycle. A request seen in IDLE at edge N gives sdram_req=1 after edge N.
- sdram_req falls on the edge after sdram_fill is sampled.
- Port occupancy per fill: 1 (grant) + controller latency + BURST_LEN cycles. The arbiter is back in IDLE on the edge after the last data word.
- Back-to-back fills: the next grant is issued in the first IDLE cycle, with no extra dead cycles.
- Clients must drop req no later than the cycle after their fill. The cache does this, so no stale re-grant occurs.
- sdram_addr and sdram_rw are stable from the grant edge until IDLE is re-entered.

## Test plan
- **Single request:** c0_req=1, c0_addr=0x0001_2340, fill 3 cycles later.
  - sdram_req=1 one cycle after c0_req, sdram_addr=0x0001_2340.
  - c0_fill pulses once and c1_fill stays 0.
  - grant=01 for 3+BURST_LEN cycles, then 00.
- **Simultaneous requests after reset:** c0_req and c1_req both rise together.
  - Client 0 is served first, then client 1 with c1_addr.
  - Repeating the simultaneous request serves client 1 first, confirming round-robin.
- **Request during another client's burst:** c1_req rises while client 0 is in BURST.
  - sdram_addr does not change until client 0's burst ends.
  - Client 1 is granted in the first IDLE cycle.
- **Stray fill:** sdram_fill=1 while idle.
  - No c*_fill, state stays IDLE, sdram_req stays 0.
- **Reset mid-burst:** reset asserted in BURST at word 2.
  - All outputs return to their reset values immediately.
  - After reset is released, a new c1_req is granted normally.
- **Granted client drops req before fill:** c0_req deasserts while in WAITFILL.
  - sdram_req stays high until the fill arrives.
  - The burst completes, and a pending c1_req is granted afterward.

Source files
------------

// File: rtl/cache_fill_arbiter_if.sv
// rtl/cache_fill_arbiter_if.sv - client, controller and debug signals of the fill arbiter
interface cache_fill_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              c0_req;
    logic [ADDR_W-1:0] c0_addr;
    logic              c0_rw;
    logic              c0_fill;
    logic              c1_req;
    logic [ADDR_W-1:0] c1_addr;
    logic              c1_rw;
    logic              c1_fill;
    logic              sdram_req;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_rw;
    logic              sdram_fill;
    logic [1:0]        grant;

    modport slave (
        input  c0_req, c0_addr, c0_rw, c1_req, c1_addr, c1_rw, sdram_fill,
        output c0_fill, c1_fill, sdram_req, sdram_addr, sdram_rw, grant
    );

    modport master (
        output c0_req, c0_addr, c0_rw, c1_req, c1_addr, c1_rw, sdram_fill,
        input  c0_fill, c1_fill, sdram_req, sdram_addr, sdram_rw, grant
    );
endinterface

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - round-robin arbiter sharing one SDRAM read port between two cache fills
module cache_fill_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_fill_arbiter_if.slave  bus
);
    localparam int CNT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAITFILL = 2'd1,
        S_BURST    = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_sdram_req;
    logic [ADDR_W-1:0] r_sdram_addr;
    logic              r_sdram_rw;
    logic [1:0]        r_grant;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_wcnt;

    logic w_pick0;
    logic w_pick1;
    logic w_in_wait;

    // r_last_grant = 1 means client 1 was served last, so client 0 wins a tie
    assign w_pick1   = bus.c1_req & (~bus.c0_req | ~r_last_grant);
    assign w_pick0   = bus.c0_req & ~w_pick1;
    assign w_in_wait = (r_state == S_WAITFILL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sdram_req  <= 1'b0;
            r_sdram_addr <= '0;
            r_sdram_rw   <= 1'b1;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
            r_wcnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick1) begin
                        r_sdram_addr <= bus.c1_addr;
                        r_sdram_rw   <= bus.c1_rw;
                        r_sdram_req  <= 1'b1;
                        r_grant      <= 2'b10;
                        r_last_grant <= 1'b1;
                        r_state      <= S_WAITFILL;
                    end else if (w_pick0) begin
                        r_sdram_addr <= bus.c0_addr;
                        r_sdram_rw   <= bus.c0_rw;
                        r_sdram_req  <= 1'b1;
                        r_grant      <= 2'b01;
                        r_last_grant <= 1'b0;
                        r_state      <= S_WAITFILL;
                    end
                end
                S_WAITFILL: begin
                    // the controller is committed once granted, so wait even if the client lets go
                    if (bus.sdram_fill) begin
                        r_sdram_req <= 1'b0;
                        r_wcnt      <= CNT_W'(BURST_LEN - 2);
                        r_state     <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (r_wcnt == '0) begin
                        r_grant <= 2'b00;
                        r_state <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // strobe is combinational so it lines up with the first data word
    assign bus.c0_fill    = bus.sdram_fill & w_in_wait & r_grant[0];
    assign bus.c1_fill    = bus.sdram_fill & w_in_wait & r_grant[1];
    assign bus.sdram_req  = r_sdram_req;
    assign bus.sdram_addr = r_sdram_addr;
    assign bus.sdram_rw   = r_sdram_rw;
    assign bus.grant      = r_grant;
endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - scoreboard bench for cache_fill_arbiter
module tb_cache_fill_arbiter;
    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_fill_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    cache_fill_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]        grant;
        logic [ADDR_W-1:0] addr;
        logic              rw;
    } gnt_t;

    gnt_t       exp_gnt[$];
    logic [1:0] exp_fill[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // monitor: a new grant or a fill strobe pops the next expected response
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        gnt_t       e;
        logic [1:0] f;
        if (bus.sdram_req === 1'b1 && prev_req !== 1'b1) begin
            if (exp_gnt.size() == 0) check("unexpected_grant", 64'd1, 64'd0);
            else begin
                e = exp_gnt.pop_front();
                check("grant_owner", 64'(bus.grant), 64'(e.grant));
                check("grant_addr", 64'(bus.sdram_addr), 64'(e.addr));
                check("grant_rw", 64'(bus.sdram_rw), 64'(e.rw));
            end
        end
        if (bus.c0_fill === 1'b1 || bus.c1_fill === 1'b1) begin
            if (exp_fill.size() == 0) check("unexpected_fill", 64'({bus.c1_fill, bus.c0_fill}), 64'd0);
            else begin
                f = exp_fill.pop_front();
                check("fill_steer", 64'({bus.c1_fill, bus.c0_fill}), 64'(f));
            end
        end
        prev_req <= bus.sdram_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) bus.c0_req = v;
        else          bus.c1_req = v;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   64'(bus.sdram_req), 64'd0);
        check({tag, "_addr"},  64'(bus.sdram_addr), 64'd0);
        check({tag, "_rw"},    64'(bus.sdram_rw), 64'd1);
        check({tag, "_grant"}, 64'(bus.grant), 64'd0);
        check({tag, "_fills"}, 64'({bus.c1_fill, bus.c0_fill}), 64'd0);
    endtask

    // entered just after the grant edge; fill comes in the lat-th WAITFILL cycle
    task automatic serve(input int lat, input int who, input logic [ADDR_W-1:0] addr,
                         input bit drop_early, input bit raise1);
        int gcyc   = 0;
        int guard  = 0;
        bit req_ok = 1'b1;
        bit adr_ok = 1'b1;
        if (drop_early) set_req(who, 1'b0);
        for (int i = 0; i < lat; i++) begin
            if (bus.grant !== 2'b00) gcyc++;
            req_ok = req_ok & (bus.sdram_req === 1'b1);
            adr_ok = adr_ok & (bus.sdram_addr === addr);
            if (i == lat - 1) begin
                bus.sdram_fill = 1'b1;
                exp_fill.push_back(who == 0 ? 2'b01 : 2'b10);
            end
            tick();
        end
        bus.sdram_fill = 1'b0;
        if (!drop_early) set_req(who, 1'b0);
        if (raise1) bus.c1_req = 1'b1;
        while (bus.grant !== 2'b00 && guard < 50) begin
            gcyc++;
            req_ok = req_ok & (bus.sdram_req === 1'b0);
            adr_ok = adr_ok & (bus.sdram_addr === addr);
            tick();
            guard++;
        end
        check("grant_len", 64'(gcyc), 64'(lat + BURST_LEN - 1));
        check("req_hold", 64'(req_ok), 64'd1);
        check("addr_stable", 64'(adr_ok), 64'd1);
    endtask

    initial begin
        bus.c0_req = 0; bus.c0_addr = '0; bus.c0_rw = 1;
        bus.c1_req = 0; bus.c1_addr = '0; bus.c1_rw = 1;
        bus.sdram_fill = 0;
        reset = 1'b1;
        tick();
        tick();
        bus.sdram_fill = 1'b1;
        #1;
        check_reset_vals("reset");
        bus.sdram_fill = 1'b0;
        reset = 1'b0;
        tick();

        // single request from client 0
        bus.c0_addr = 32'h0001_2340; bus.c0_rw = 1'b1; bus.c0_req = 1'b1;
        exp_gnt.push_back('{2'b01, 32'h0001_2340, 1'b1});
        tick();
        check("single_req_latency", 64'(bus.sdram_req), 64'd1);
        check("single_grant", 64'(bus.grant), 64'd1);
        serve(4, 0, 32'h0001_2340, 1'b0, 1'b0);
        check("single_idle_req", 64'(bus.sdram_req), 64'd0);

        // stray fill while idle
        bus.sdram_fill = 1'b1;
        #1;
        check("stray_fills", 64'({bus.c1_fill, bus.c0_fill}), 64'd0);
        tick();
        check("stray_req", 64'(bus.sdram_req), 64'd0);
        bus.sdram_fill = 1'b0;
        tick();
        check("stray_grant", 64'(bus.grant), 64'd0);

        // tie with client 0 served last: client 1 first
        bus.c0_addr = 32'h1000_0000; bus.c0_rw = 1'b0; bus.c0_req = 1'b1;
        bus.c1_addr = 32'h2000_0040; bus.c1_rw = 1'b1; bus.c1_req = 1'b1;
        exp_gnt.push_back('{2'b10, 32'h2000_0040, 1'b1});
        exp_gnt.push_back('{2'b01, 32'h1000_0000, 1'b0});
        tick();
        check("rr_first", 64'(bus.grant), 64'd2);
        serve(2, 1, 32'h2000_0040, 1'b0, 1'b0);
        tick();
        check("rr_second", 64'(bus.grant), 64'd1);
        serve(3, 0, 32'h1000_0000, 1'b0, 1'b0);

        // after reset a tie goes to client 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.c0_addr = 32'h0000_0100; bus.c0_rw = 1'b1; bus.c0_req = 1'b1;
        bus.c1_addr = 32'h0000_0200; bus.c1_rw = 1'b0; bus.c1_req = 1'b1;
        exp_gnt.push_back('{2'b01, 32'h0000_0100, 1'b1});
        exp_gnt.push_back('{2'b10, 32'h0000_0200, 1'b0});
        tick();
        check("tie_after_reset", 64'(bus.grant), 64'd1);
        serve(1, 0, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        check("tie_second", 64'(bus.grant), 64'd2);
        serve(2, 1, 32'h0000_0200, 1'b0, 1'b0);

        // client 1 requests during client 0's burst
        bus.c0_addr = 32'hAAAA_0000; bus.c0_rw = 1'b1; bus.c0_req = 1'b1;
        bus.c1_addr = 32'hBBBB_0010; bus.c1_rw = 1'b1;
        exp_gnt.push_back('{2'b01, 32'hAAAA_0000, 1'b1});
        exp_gnt.push_back('{2'b10, 32'hBBBB_0010, 1'b1});
        tick();
        serve(2, 0, 32'hAAAA_0000, 1'b0, 1'b1);
        tick();
        check("pending_grant", 64'(bus.grant), 64'd2);
        check("pending_addr", 64'(bus.sdram_addr), 64'hBBBB_0010);
        serve(3, 1, 32'hBBBB_0010, 1'b0, 1'b0);

        // reset in BURST at word 2
        bus.c0_addr = 32'h0000_4440; bus.c0_rw = 1'b0; bus.c0_req = 1'b1;
        exp_gnt.push_back('{2'b01, 32'h0000_4440, 1'b0});
        tick();
        bus.sdram_fill = 1'b1;
        exp_fill.push_back(2'b01);
        tick();
        bus.sdram_fill = 1'b0;
        check("midburst_grant", 64'(bus.grant), 64'd1);
        tick();
        reset = 1'b1;
        #1;
        check_reset_vals("midburst_reset");
        bus.c0_req = 1'b0;
        tick();
        reset = 1'b0;
        bus.c1_addr = 32'h0000_5550; bus.c1_rw = 1'b1; bus.c1_req = 1'b1;
        exp_gnt.push_back('{2'b10, 32'h0000_5550, 1'b1});
        tick();
        check("post_reset_grant", 64'(bus.grant), 64'd2);
        serve(2, 1, 32'h0000_5550, 1'b0, 1'b0);

        // granted client drops req before fill; pending client 1 follows
        bus.c0_addr = 32'h0000_6660; bus.c0_rw = 1'b1; bus.c0_req = 1'b1;
        exp_gnt.push_back('{2'b01, 32'h0000_6660, 1'b1});
        tick();
        bus.c1_addr = 32'h0000_7770; bus.c1_rw = 1'b0; bus.c1_req = 1'b1;
        exp_gnt.push_back('{2'b10, 32'h0000_7770, 1'b0});
        serve(3, 0, 32'h0000_6660, 1'b1, 1'b0);
        tick();
        check("drop_next_grant", 64'(bus.grant), 64'd2);
        serve(2, 1, 32'h0000_7770, 1'b0, 1'b0);

        tick();
        tick();
        check("grants_consumed", 64'(exp_gnt.size()), 64'd0);
        check("fills_consumed", 64'(exp_fill.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
